// File: rtl/rs_pkg.sv
// Shared types for the reservation-station dispatch / CDB slice:
// station entry layout, ALU opcode encoding and default sizes.
package rs_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int TAG_W_DEF   = 4;
    localparam int XLEN_DEF    = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } rs_alu_op_t;

    typedef struct packed {
        logic [6:0]           operation;
        logic [TAG_W_DEF-1:0] tag;
        logic                 busy_r1;
        logic                 busy_r2;
        logic [XLEN_DEF-1:0]  r1;
        logic [XLEN_DEF-1:0]  r2;
        logic [XLEN_DEF-1:0]  pc;
        logic                 sent_to_alu;
    } rs_t;

endpackage

// File: rtl/rs_alu.sv
// Purely combinational integer ALU shared by the functional units.
// Unlisted opcodes produce zero; shifts use the low five bits of r2.
module rs_alu
    import rs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] r1_i,
    input  logic [XLEN-1:0] r2_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt_s;
    assign shamt_s = r2_i[4:0];

    // Result mux over the supported operations.
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = r1_i + r2_i;
            OP_SUB:  result_o = r1_i - r2_i;
            OP_AND:  result_o = r1_i & r2_i;
            OP_OR:   result_o = r1_i | r2_i;
            OP_XOR:  result_o = r1_i ^ r2_i;
            OP_SLL:  result_o = r1_i << shamt_s;
            OP_SRL:  result_o = r1_i >> shamt_s;
            OP_SRA:  result_o = $signed(r1_i) >>> shamt_s;
            OP_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(r1_i) < $signed(r2_i))};
            OP_SLTU: result_o = {{(XLEN-1){1'b0}}, (r1_i < r2_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rs_dispatch_cdb.sv
// Reservation-station dispatch into a two-stage EX/WB pipe and CDB producer.
// Optional macro RS_DISPATCH_RR_EN: round-robin selection starting after the
// last issued index; when undefined, lowest index wins and no pointer exists.
module rs_dispatch_cdb
    import rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int XLEN    = XLEN_DEF,
    localparam int IDX_W  = $clog2(RS_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [RS_SIZE-1:0] rs_valid,
    input  logic [RS_SIZE-1:0] rs_ready,
    input  rs_t                rs_data [RS_SIZE],
    output logic               sent_valid,
    output logic [IDX_W-1:0]   sent_idx,
    output logic               cdb_req,
    input  logic               cdb_grant,
    output logic               cdb_valid,
    output logic [TAG_W-1:0]   cdb_tag,
    output logic [XLEN-1:0]    cdb_value,
    output logic [RS_SIZE-1:0] rs_done
);

    // Pipeline state
    logic               ex_v_q,   ex_v_d;
    logic [3:0]         ex_op_q,  ex_op_d;
    logic [TAG_W-1:0]   ex_tag_q, ex_tag_d;
    logic [XLEN-1:0]    ex_r1_q,  ex_r1_d;
    logic [XLEN-1:0]    ex_r2_q,  ex_r2_d;
    logic [IDX_W-1:0]   ex_idx_q, ex_idx_d;
    logic               wb_v_q,   wb_v_d;
    logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
    logic [XLEN-1:0]    wb_val_q, wb_val_d;
    logic [IDX_W-1:0]   wb_idx_q, wb_idx_d;
    logic [RS_SIZE-1:0] inflight_q, inflight_d;

    logic [RS_SIZE-1:0] cand_s;
    logic [RS_SIZE-1:0] rs_done_s;
    logic [IDX_W-1:0]   start_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               found_s;
    logic               cdb_valid_s;
    logic               wb_free_s;
    logic               ex_adv_s;
    logic               issue_s;
    logic [XLEN-1:0]    alu_res_s;
    logic [RS_SIZE-1:0] unused_s;

`ifdef RS_DISPATCH_RR_EN
    logic [IDX_W-1:0] rr_q, rr_d;

    assign start_s = rr_q + IDX_W'(1);

    // Pointer remembers the last issued index; moves only on issue.
    always_comb begin
        if (issue_s) begin
            rr_d = sel_idx_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign start_s = '0;
`endif

    // WB drains only on an unflushed grant; EX moves when anything ahead frees.
    assign cdb_valid_s = wb_v_q & cdb_grant & ~flush;
    assign wb_free_s   = ~wb_v_q | cdb_valid_s;
    assign ex_adv_s    = ~ex_v_q | wb_free_s;
    assign rs_done_s   = cdb_valid_s ? ({{(RS_SIZE-1){1'b0}}, 1'b1} << wb_idx_q) : '0;
    // An entry whose done pulses now is still visible to us until the next edge.
    assign cand_s      = rs_valid & rs_ready & ~inflight_q & ~rs_done_s;
    assign issue_s     = found_s & ex_adv_s & ~flush & rst;

    // First candidate found scanning upward from start_s with wrap.
    always_comb begin
        int k;
        found_s   = 1'b0;
        sel_idx_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            k = (int'(start_s) + i) % RS_SIZE;
            if (!found_s && cand_s[k]) begin
                found_s   = 1'b1;
                sel_idx_s = IDX_W'(k);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Station fields this unit does not consume.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            unused_s[i] = ^{rs_data[i].busy_r1, rs_data[i].busy_r2, rs_data[i].pc,
                            rs_data[i].sent_to_alu, rs_data[i].operation[6:4]};
        end
    end

    rs_alu #(.XLEN(XLEN)) u_alu (
        .op_i     (ex_op_q),
        .r1_i     (ex_r1_q),
        .r2_i     (ex_r2_q),
        .result_o (alu_res_s)
    );

    // Next-state for EX, WB and the in-flight mask; flush squashes everything.
    always_comb begin
        ex_v_d     = ex_v_q;
        ex_op_d    = ex_op_q;
        ex_tag_d   = ex_tag_q;
        ex_r1_d    = ex_r1_q;
        ex_r2_d    = ex_r2_q;
        ex_idx_d   = ex_idx_q;
        wb_v_d     = wb_v_q;
        wb_tag_d   = wb_tag_q;
        wb_val_d   = wb_val_q;
        wb_idx_d   = wb_idx_q;
        inflight_d = inflight_q;
        if (flush) begin
            ex_v_d     = 1'b0;
            wb_v_d     = 1'b0;
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q & ~rs_done_s;
            if (issue_s) begin
                inflight_d[sel_idx_s] = 1'b1;
            end else begin
                inflight_d = inflight_d;
            end
            if (wb_free_s) begin
                wb_v_d   = ex_v_q;
                wb_tag_d = ex_tag_q;
                wb_val_d = alu_res_s;
                wb_idx_d = ex_idx_q;
            end else begin
                wb_v_d   = wb_v_q;
            end
            if (ex_adv_s) begin
                ex_v_d = issue_s;
                if (issue_s) begin
                    ex_op_d  = rs_data[sel_idx_s].operation[3:0];
                    ex_tag_d = rs_data[sel_idx_s].tag;
                    ex_r1_d  = rs_data[sel_idx_s].r1;
                    ex_r2_d  = rs_data[sel_idx_s].r2;
                    ex_idx_d = sel_idx_s;
                end else begin
                    ex_idx_d = ex_idx_q;
                end
            end else begin
                ex_v_d = ex_v_q;
            end
        end
    end

    // Pipeline and in-flight registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v_q     <= 1'b0;
            ex_op_q    <= '0;
            ex_tag_q   <= '0;
            ex_r1_q    <= '0;
            ex_r2_q    <= '0;
            ex_idx_q   <= '0;
            wb_v_q     <= 1'b0;
            wb_tag_q   <= '0;
            wb_val_q   <= '0;
            wb_idx_q   <= '0;
            inflight_q <= '0;
        end else begin
            ex_v_q     <= ex_v_d;
            ex_op_q    <= ex_op_d;
            ex_tag_q   <= ex_tag_d;
            ex_r1_q    <= ex_r1_d;
            ex_r2_q    <= ex_r2_d;
            ex_idx_q   <= ex_idx_d;
            wb_v_q     <= wb_v_d;
            wb_tag_q   <= wb_tag_d;
            wb_val_q   <= wb_val_d;
            wb_idx_q   <= wb_idx_d;
            inflight_q <= inflight_d;
        end
    end

    assign sent_valid = issue_s;
    assign sent_idx   = issue_s ? sel_idx_s : '0;
    assign cdb_req    = wb_v_q;
    assign cdb_valid  = cdb_valid_s;
    assign cdb_tag    = wb_tag_q;
    assign cdb_value  = wb_val_q;
    assign rs_done    = rs_done_s;

endmodule

// File: tb/tb_rs_dispatch_cdb.sv
// Directed bench for rs_dispatch_cdb (default fixed-priority build).
module tb_rs_dispatch_cdb;
    import rs_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [7:0]  rs_valid;
    logic [7:0]  rs_ready;
    rs_t         rs_data [8];
    logic        sent_valid;
    logic [2:0]  sent_idx;
    logic        cdb_req;
    logic        cdb_grant;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [7:0]  rs_done;

    int checks = 0;
    int fails  = 0;

    rs_dispatch_cdb dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data),
        .sent_valid(sent_valid), .sent_idx(sent_idx),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_value(cdb_value), .rs_done(rs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int idx, input logic [6:0] op, input logic [3:0] tag,
                             input logic [31:0] r1, input logic [31:0] r2);
        rs_data[idx].operation = op;
        rs_data[idx].tag       = tag;
        rs_data[idx].r1        = r1;
        rs_data[idx].r2        = r2;
        rs_valid[idx]          = 1'b1;
        rs_ready[idx]          = 1'b1;
    endtask

    task automatic clr(input int idx);
        rs_valid[idx] = 1'b0;
        rs_ready[idx] = 1'b0;
    endtask

    task automatic nc;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
        rs_valid = 8'h00; rs_ready = 8'h00;
        for (int i = 0; i < 8; i++) rs_data[i] = '0;
        #2 rst = 1'b0;
        set_entry(2, 7'h00, 4'h1, 32'd1, 32'd1);
        #1;
        chk("rst_sent_valid", 32'(sent_valid), 32'd0);
        chk("rst_cdb_req",    32'(cdb_req),    32'd0);
        chk("rst_cdb_valid",  32'(cdb_valid),  32'd0);
        chk("rst_rs_done",    32'(rs_done),    32'd0);
        clr(2);
        nc; nc; rst = 1'b1;

        // Basic ADD, high opcode bits must be ignored
        nc; set_entry(3, 7'h70, 4'h9, 32'd5, 32'd7); cdb_grant = 1'b1; #1;
        chk("t1_sent_valid", 32'(sent_valid), 32'd1);
        chk("t1_sent_idx",   32'(sent_idx),   32'd3);
        chk("t1_req_c0",     32'(cdb_req),    32'd0);
        nc; #1;
        chk("t1_no_resend",  32'(sent_valid), 32'd0);
        chk("t1_req_c1",     32'(cdb_req),    32'd0);
        nc; #1;
        chk("t1_cdb_valid",  32'(cdb_valid),  32'd1);
        chk("t1_cdb_tag",    32'(cdb_tag),    32'd9);
        chk("t1_cdb_value",  cdb_value,       32'd12);
        chk("t1_rs_done",    32'(rs_done),    32'h08);
        clr(3);
        nc; #1;
        chk("t1_req_after",  32'(cdb_req),    32'd0);
        chk("t1_done_after", 32'(rs_done),    32'd0);

        // Three entries at once: fixed priority order 1, 4, 6
        nc;
        set_entry(1, 7'h02, 4'h1, 32'h0000_F0F0, 32'h0000_FF00);
        set_entry(4, 7'h03, 4'h4, 32'h0000_00F0, 32'h0000_000F);
        set_entry(6, 7'h04, 4'h6, 32'h0000_00FF, 32'h0000_000F);
        #1;
        chk("t2_idx_a", 32'(sent_idx), 32'd1);
        nc; #1;
        chk("t2_idx_b", 32'(sent_idx), 32'd4);
        nc; #1;
        chk("t2_idx_c",   32'(sent_idx),  32'd6);
        chk("t2_tag_a",   32'(cdb_tag),   32'd1);
        chk("t2_val_and", cdb_value,      32'h0000_F000);
        chk("t2_done_a",  32'(rs_done),   32'h02);
        clr(1);
        nc; #1;
        chk("t2_sent_none", 32'(sent_valid), 32'd0);
        chk("t2_tag_b",     32'(cdb_tag),    32'd4);
        chk("t2_val_or",    cdb_value,       32'h0000_00FF);
        clr(4);
        nc; #1;
        chk("t2_tag_c",     32'(cdb_tag),    32'd6);
        chk("t2_val_xor",   cdb_value,       32'h0000_00F0);
        chk("t2_done_c",    32'(rs_done),    32'h40);
        clr(6);
        nc; #1;
        chk("t2_req_idle",  32'(cdb_req),    32'd0);

        // Grant withheld: WB holds, EX stalls, no further dispatch
        nc; cdb_grant = 1'b0;
        set_entry(0, 7'h01, 4'h2, 32'd0, 32'd1);
        set_entry(2, 7'h00, 4'h3, 32'd3, 32'd4);
        #1;
        chk("t3_idx0", 32'(sent_idx), 32'd0);
        nc; #1;
        chk("t3_idx2", 32'(sent_idx), 32'd2);
        nc; set_entry(5, 7'h03, 4'h5, 32'd1, 32'd2); #1;
        chk("t3_req_s1",   32'(cdb_req),    32'd1);
        chk("t3_valid_s1", 32'(cdb_valid),  32'd0);
        chk("t3_val_s1",   cdb_value,       32'hFFFF_FFFF);
        chk("t3_sent_s1",  32'(sent_valid), 32'd0);
        nc; #1;
        chk("t3_sent_s2",  32'(sent_valid), 32'd0);
        chk("t3_done_s2",  32'(rs_done),    32'd0);
        nc; #1;
        chk("t3_req_s3",   32'(cdb_req),    32'd1);
        chk("t3_sent_s3",  32'(sent_valid), 32'd0);
        nc; cdb_grant = 1'b1; #1;
        chk("t3_valid_g",  32'(cdb_valid),  32'd1);
        chk("t3_tag_g",    32'(cdb_tag),    32'd2);
        chk("t3_val_g",    cdb_value,       32'hFFFF_FFFF);
        chk("t3_done_g",   32'(rs_done),    32'h01);
        chk("t3_sent_g",   32'(sent_idx),   32'd5);
        clr(0);
        nc; #1;
        chk("t3_tag_b2b",  32'(cdb_tag),    32'd3);
        chk("t3_val_b2b",  cdb_value,       32'd7);
        chk("t3_done_b2b", 32'(rs_done),    32'h04);
        clr(2);
        nc; #1;
        chk("t3_tag_5",    32'(cdb_tag),    32'd5);
        chk("t3_val_5",    cdb_value,       32'd3);
        clr(5);
        nc; #1;
        chk("t3_req_idle", 32'(cdb_req),    32'd0);

        // Shift and compare corner cases, plus an unlisted opcode
        nc;
        set_entry(0, 7'h07, 4'h1, 32'h8000_0000, 32'h0000_0021);
        set_entry(1, 7'h09, 4'h2, 32'd1, 32'hFFFF_FFFF);
        set_entry(2, 7'h08, 4'h3, 32'd1, 32'hFFFF_FFFF);
        set_entry(3, 7'h0F, 4'h4, 32'd5, 32'd5);
        nc; nc; #1;
        chk("t4_sra",  cdb_value, 32'hC000_0000);
        clr(0);
        nc; #1;
        chk("t4_sltu", cdb_value, 32'd1);
        clr(1);
        nc; #1;
        chk("t4_slt",  cdb_value, 32'd0);
        clr(2);
        nc; #1;
        chk("t4_unl_valid", 32'(cdb_valid), 32'd1);
        chk("t4_unl_tag",   32'(cdb_tag),   32'd4);
        chk("t4_unl_val",   cdb_value,      32'd0);
        clr(3);
        nc;

        // Flush with EX and WB full and grant high
        nc; cdb_grant = 1'b0;
        set_entry(3, 7'h00, 4'hA, 32'd1, 32'd1);
        set_entry(6, 7'h00, 4'hB, 32'd2, 32'd2);
        nc; nc; flush = 1'b1; cdb_grant = 1'b1; #1;
        chk("t5_req_pre",   32'(cdb_req),    32'd1);
        chk("t5_valid_fl",  32'(cdb_valid),  32'd0);
        chk("t5_sent_fl",   32'(sent_valid), 32'd0);
        chk("t5_done_fl",   32'(rs_done),    32'd0);
        nc; flush = 1'b0; #1;
        chk("t5_req_post",  32'(cdb_req),    32'd0);
        chk("t5_resend",    32'(sent_valid), 32'd1);
        chk("t5_resend_ix", 32'(sent_idx),   32'd3);
        nc; #1;
        chk("t5_resend6",   32'(sent_idx),   32'd6);
        nc; #1;
        chk("t5_tag_a",     32'(cdb_tag),    32'hA);
        chk("t5_val_a",     cdb_value,       32'd2);
        clr(3);
        nc; #1;
        chk("t5_tag_b",     32'(cdb_tag),    32'hB);
        chk("t5_val_b",     cdb_value,       32'd4);
        clr(6);
        nc; #1;
        chk("t5_req_idle",  32'(cdb_req),    32'd0);

        // Asynchronous reset in the middle of a stall
        nc; cdb_grant = 1'b0;
        set_entry(1, 7'h00, 4'h7, 32'd10, 32'd20);
        #1;
        chk("t6_idx1", 32'(sent_idx), 32'd1);
        nc; nc; #1;
        chk("t6_req_stall", 32'(cdb_req), 32'd1);
        #1 rst = 1'b0;
        set_entry(4, 7'h00, 4'h8, 32'd1, 32'd2);
        #1;
        chk("t6_rst_req",   32'(cdb_req),    32'd0);
        chk("t6_rst_valid", 32'(cdb_valid),  32'd0);
        chk("t6_rst_tag",   32'(cdb_tag),    32'd0);
        chk("t6_rst_value", cdb_value,       32'd0);
        chk("t6_rst_sent",  32'(sent_valid), 32'd0);
        chk("t6_rst_done",  32'(rs_done),    32'd0);
        nc; nc; rst = 1'b1; #1;
        chk("t6_first_sent", 32'(sent_valid), 32'd1);
        chk("t6_first_idx",  32'(sent_idx),   32'd1);
        nc; #1;
        chk("t6_second_idx", 32'(sent_idx),   32'd4);
        nc; cdb_grant = 1'b1; #1;
        chk("t6_tag",   32'(cdb_tag), 32'd7);
        chk("t6_value", cdb_value,    32'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_cdb.md
Name: rs_dispatch_cdb

Overview:
- Consumer side of the reservation station array and producer of the common data bus (CDB) that the stations and ROB snoop.
- Each cycle it selects one occupied, operand-ready, not-yet-dispatched station entry and latches its operands into a 2-stage execute pipe (EX, WB).
- It computes the ALU result and holds it in WB until the CDB arbiter grants the bus.
- On grant it drives tag/value on the CDB and pulses a one-hot done back to the originating station index so that station frees itself.

Parameters:
- RS_SIZE, 8, number of station entries snooped; index width IDX_W = $clog2(RS_SIZE)
- TAG_W, 4, ROB tag width
- XLEN, 32, operand/result width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- flush  in  1  synchronous squash of all in-flight work
- rs_valid  in  RS_SIZE  entry occupied
- rs_ready  in  RS_SIZE  both operands resolved
- rs_data  in  rs_t[RS_SIZE]  operation, tag, r1, r2 per entry
- sent_valid  out  1  pulse: an entry was dispatched this cycle
- sent_idx  out  IDX_W  index dispatched; the station sets its sent_to_alu flag
- cdb_req  out  1  WB holds a result
- cdb_grant  in  1  arbiter accepts the result this cycle
- cdb_valid  out  1  equals cdb_req && cdb_grant
- cdb_tag  out  TAG_W  ROB tag of the result
- cdb_value  out  XLEN  result
- rs_done  out  RS_SIZE  one-hot of the WB station index when cdb_valid, else 0

Behaviour:
- Reset (rst=0, async):
  - EX/WB valid=0, inflight mask=0, RR pointer=0.
  - All outputs 0.
- Candidate mask: rs_valid & rs_ready & ~inflight & ~rs_done.
  - Excluding rs_done prevents re-picking an entry whose done pulses this cycle, because the station clears that entry only at the next edge.
- Select: lowest-index set candidate.
- Issue condition: a candidate exists && EX can advance.
  - EX can advance when EX is empty, or WB is empty, or WB drains this cycle (cdb_valid).
- On issue:
  - sent_valid=1 and sent_idx=index, combinationally in the issue cycle.
  - At the edge: EX latches op/tag/r1/r2/idx and the inflight bit for that index sets.
- EX→WB at the edge when WB is empty or draining.
  - result = f(op, r1, r2) is computed combinationally from the EX registers and latched into WB.
- WB holds while cdb_req && !cdb_grant; EX stalls behind it; no dispatch occurs while EX is stalled.
- Grant: cdb_valid=1, cdb_tag/cdb_value driven from WB, rs_done[idx]=1; the inflight bit clears at that edge.
- Latency: entry ready in cycle N with the pipe empty → dispatched in N → cdb_req in N+2. Throughput is 1 result/cycle under continuous grant.
- ALU ops (operation[3:0] per rs_alu_op_t):
  - ADD, SUB, AND, OR, XOR: XLEN-bit, wrap-around.
  - SLL, SRL, SRA: shift by r2[4:0].
  - SLT (signed), SLTU (unsigned): result 0 or 1.
  - Unlisted codes: result 0, still broadcast.
  - operation[6:4] is ignored.
- Flush:
  - At the edge: EX/WB valid=0 and inflight=0; the RR pointer is unchanged.
  - In the flush cycle itself, cdb_valid, sent_valid and rs_done are forced to 0 regardless of grant.
- Simultaneous flush and rst: rst dominates.
- An entry that deasserts rs_valid while in flight (e.g. a station-side clear) still completes and broadcasts unless flushed.

Optional Feature:
- Macro: RS_DISPATCH_RR_EN.
- Defined: round-robin select. The search starts at (last_issued_idx+1) mod RS_SIZE and wraps. The pointer updates only on issue.
- Undefined: fixed priority, lowest index wins; no pointer register is instantiated.

Decomposition:
- Shared package (rs_pkg):
  - rs_t struct (operation[6:0], tag[TAG_W-1:0], busy_r1, busy_r2, r1, r2, pc, sent_to_alu).
  - rs_alu_op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - Constants RS_SIZE_DEF=8 and TAG_W_DEF=4.
- One sub-module, rs_alu: purely combinational op/r1/r2 → result. It is reused by other functional units.

Test Plan:
- Entry 3 ready, op ADD, r1=5, r2=7, tag=9, grant held 1 → sent_idx=3 in cycle 0; cycle 2 cdb_valid=1, tag=9, value=12, rs_done=8'b0000_1000.
- Entries 1, 4, 6 ready at once, grant=1 → dispatch order 1, 4, 6 (fixed priority); with RS_DISPATCH_RR_EN and last issued=4 → order 6, 1, 4.
- Entry 0 SUB r1=0, r2=1; grant low 3 cycles → cdb_req stays 1 with value 32'hFFFF_FFFF; entry 2 stalls in EX; no second dispatch; on grant the results broadcast back-to-back.
- SRA r1=32'h8000_0000, r2=32'h0000_0021 → value 32'hC000_0000 (shift 1); SLTU r1=1, r2=32'hFFFF_FFFF → 1; SLT with the same operands → 0.
- With EX and WB full, flush=1 with grant=1 → cdb_valid=0 that cycle; next cycle cdb_req=0, inflight=0, and the same entries become dispatchable again.
- rst driven low mid-stall with no clock edge → all outputs 0 immediately; after release, the first ready entry dispatches in the first cycle.
